// File: rtl/press_count_display_pkg.sv
// Shared definitions for the press counter: 7-segment code table and BCD helper.
// Segment vectors are active-low with bit6 = A down to bit0 = G.
package press_count_display_pkg;

  typedef logic [6:0] seg_t;

  // Bit-order definition: the first member lands in bit6 (segment A).
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_bits_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    logic [7:0] result;
    if (value[3:0] == 4'd9) begin
      result[3:0] = 4'd0;
      if (value[7:4] == 4'd9) begin
        result[7:4] = 4'd0;
      end else begin
        result[7:4] = value[7:4] + 4'd1;
      end
    end else begin
      result[3:0] = value[3:0] + 4'd1;
      result[7:4] = value[7:4];
    end
    return result;
  endfunction

endpackage

// File: rtl/press_count_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-decimal codes decode to blank.
module bcd_to_7seg
  import press_count_display_pkg::*;
(
  input  logic [3:0] digit,
  output seg_t       seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/press_count_display.sv
// Counts switch releases as two BCD digits, clears on a long press, and drives
// two registered active-low 7-segment displays that trail the count by one cycle.
module press_count_display
  import press_count_display_pkg::*;
#(
  parameter int CLEAR_CYCLES  = 50000000,
  parameter int BLANK_LEADING = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  output logic [7:0] o_Count,
  output logic       o_Press_Pulse,
  output logic       o_Clear_Pulse,
  output logic [6:0] o_Seg_Tens,
  output logic [6:0] o_Seg_Ones
);

  localparam int                HOLD_W     = $clog2(CLEAR_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(CLEAR_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE  = HOLD_W'(CLEAR_CYCLES - 1);
  localparam seg_t              TENS_RESET = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_0;

  logic              switch_r;
  logic [HOLD_W-1:0] hold_r;
  logic              suppress_r;
  logic [7:0]        count_r;
  logic              press_r;
  logic              clear_r;
  seg_t              seg_tens_r;
  seg_t              seg_ones_r;

  logic              release_s;
  logic              clear_s;
  logic [HOLD_W-1:0] hold_next_s;
  logic              suppress_next_s;
  logic [7:0]        count_next_s;
  logic              press_next_s;
  seg_t              tens_dec_s;
  seg_t              ones_dec_s;
  seg_t              tens_sel_s;

  assign release_s = ~i_Switch & switch_r;
  // Saturation at HOLD_MAX keeps this from matching twice in one press.
  assign clear_s   = i_Switch & (hold_r == HOLD_FIRE);

  // Next-state for hold counter, suppress flag and count
  always_comb begin
    hold_next_s     = hold_r;
    suppress_next_s = suppress_r;
    count_next_s    = count_r;
    press_next_s    = 1'b0;

    if (!i_Switch) begin
      hold_next_s = {HOLD_W{1'b0}};
    end else if (hold_r != HOLD_MAX) begin
      hold_next_s = hold_r + HOLD_W'(1);
    end else begin
      hold_next_s = hold_r;
    end

    if (clear_s) begin
      count_next_s    = 8'h00;
      suppress_next_s = 1'b1;
    end else if (release_s) begin
      if (suppress_r) begin
        suppress_next_s = 1'b0;
      end else begin
        count_next_s = bcd_inc(count_r);
        press_next_s = 1'b1;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Tens blanking ahead of the display register
  always_comb begin
    tens_sel_s = tens_dec_s;
    if ((BLANK_LEADING != 0) && (count_r[7:4] == 4'd0)) begin
      tens_sel_s = SEG_BLANK;
    end else begin
      tens_sel_s = tens_dec_s;
    end
  end

  // State and output registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      switch_r   <= 1'b0;
      hold_r     <= {HOLD_W{1'b0}};
      suppress_r <= 1'b0;
      count_r    <= 8'h00;
      press_r    <= 1'b0;
      clear_r    <= 1'b0;
      seg_tens_r <= TENS_RESET;
      seg_ones_r <= SEG_0;
    end else begin
      switch_r   <= i_Switch;
      hold_r     <= hold_next_s;
      suppress_r <= suppress_next_s;
      count_r    <= count_next_s;
      press_r    <= press_next_s;
      clear_r    <= clear_s;
      seg_tens_r <= tens_sel_s;
      seg_ones_r <= ones_dec_s;
    end
  end

  bcd_to_7seg u_tens (
    .digit (count_r[7:4]),
    .seg   (tens_dec_s)
  );

  bcd_to_7seg u_ones (
    .digit (count_r[3:0]),
    .seg   (ones_dec_s)
  );

  assign o_Count       = count_r;
  assign o_Press_Pulse = press_r;
  assign o_Clear_Pulse = clear_r;
  assign o_Seg_Tens    = seg_tens_r;
  assign o_Seg_Ones    = seg_ones_r;

endmodule

// File: tb/tb_press_count_display.sv
// Scoreboard bench: a decimal reference model queues expected outputs per clock,
// and they are popped and compared after each edge.
module tb_press_count_display;

  localparam int CC = 8;
  localparam int BL = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic [7:0] count;
  logic       press;
  logic       clear;
  logic [6:0] seg_t;
  logic [6:0] seg_o;

  typedef struct packed {
    logic [7:0] cnt;
    logic       prs;
    logic       clr;
    logic [6:0] tens;
    logic [6:0] ones;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [6:0] seg_tab [0:9];
  int         m_sw, m_hold, m_sup, m_cnt;
  int         press_seen, clear_seen;

  press_count_display #(.CLEAR_CYCLES(CC), .BLANK_LEADING(BL)) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Switch      (sw),
    .o_Count       (count),
    .o_Press_Pulse (press),
    .o_Clear_Pulse (clear),
    .o_Seg_Tens    (seg_t),
    .o_Seg_Ones    (seg_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [6:0] tens_seg(input int v);
    if ((v / 10) == 0 && BL != 0) return 7'b1111111;
    return seg_tab[v / 10];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_sw = 0; m_hold = 0; m_sup = 0; m_cnt = 0;
  endtask

  // One clock: drive, predict, push; then pop and compare after the edge.
  task automatic step(input logic s);
    exp_t e;
    bit   rel;
    bit   clr;
    sw = s;
    rel = (s == 1'b0) && (m_sw == 1);
    clr = (s == 1'b1) && (m_hold == CC - 1);
    e.tens = tens_seg(m_cnt);
    e.ones = seg_tab[m_cnt % 10];
    e.prs = 1'b0;
    e.clr = 1'b0;
    if (clr) begin
      m_cnt = 0; e.clr = 1'b1; m_sup = 1;
    end else if (rel) begin
      if (m_sup != 0) m_sup = 0;
      else begin
        m_cnt = (m_cnt + 1) % 100; e.prs = 1'b1;
      end
    end
    if (s) m_hold = (m_hold < CC) ? m_hold + 1 : CC;
    else   m_hold = 0;
    m_sw = int'(s);
    e.cnt = to_bcd(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("queue_empty", 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      chk("count", count, e.cnt);
      chk("press_pulse", {7'd0, press}, {7'd0, e.prs});
      chk("clear_pulse", {7'd0, clear}, {7'd0, e.clr});
      chk("seg_tens", {1'b0, seg_t}, {1'b0, e.tens});
      chk("seg_ones", {1'b0, seg_o}, {1'b0, e.ones});
    end
    press_seen += int'(press);
    clear_seen += int'(clear);
  endtask

  task automatic tap(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_count"}, count, 8'h00);
    chk({tag, "_press"}, {7'd0, press}, 8'd0);
    chk({tag, "_clear"}, {7'd0, clear}, 8'd0);
    chk({tag, "_tens"}, {1'b0, seg_t}, 8'h7F);
    chk({tag, "_ones"}, {1'b0, seg_o}, 8'h01);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    rst = 1'b1;
    sw = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst = 1'b0;

    // Three short presses, pulse on the first low sample
    press_seen = 0;
    for (int i = 0; i < 3; i++) begin
      repeat (3) step(1'b1);
      step(1'b0);
      chk("pulse_first_low", {7'd0, press}, 8'd1);
      step(1'b0);
      step(1'b0);
    end
    chk("three_pulses", 8'(press_seen), 8'd3);
    chk("count_03", count, 8'h03);
    chk("ones_3", {1'b0, seg_o}, 8'h06);
    chk("tens_blank3", {1'b0, seg_t}, 8'h7F);

    // 100 presses from zero with wrap
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      tap(3, 3);
      if (i == 10) begin
        chk("count_10", count, 8'h10);
        chk("tens_1", {1'b0, seg_t}, 8'h4F);
      end
      if (i == 99) chk("count_99", count, 8'h99);
      if (i == 100) begin
        chk("count_wrap", count, 8'h00);
        chk("tens_blank_wrap", {1'b0, seg_t}, 8'h7F);
      end
    end

    // Long press clears once and suppresses the release
    repeat (5) tap(3, 3);
    chk("count_05", count, 8'h05);
    clear_seen = 0;
    for (int j = 1; j <= 12; j++) begin
      step(1'b1);
      chk("clear_on_8th", {7'd0, clear}, (j == 8) ? 8'd1 : 8'd0);
    end
    chk("clear_once", 8'(clear_seen), 8'd1);
    chk("count_cleared", count, 8'h00);
    press_seen = 0;
    repeat (3) step(1'b0);
    chk("no_pulse_suppressed", 8'(press_seen), 8'd0);
    chk("count_stays_00", count, 8'h00);
    tap(3, 3);
    chk("count_01_after_clear", count, 8'h01);

    // Threshold boundary: 7 cycles counts, 8 cycles clears
    clear_seen = 0;
    tap(7, 3);
    chk("hold7_no_clear", 8'(clear_seen), 8'd0);
    chk("hold7_count", count, 8'h02);
    tap(8, 3);
    chk("hold8_clear", 8'(clear_seen), 8'd1);
    chk("hold8_count", count, 8'h00);

    // Reset in the middle of a press
    repeat (5) tap(3, 3);
    chk("mid_count_05", count, 8'h05);
    repeat (2) step(1'b1);
    rst = 1'b1;
    #1;
    chk("async_clear", count, 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_no_press", {7'd0, press}, 8'd0);
      chk("rst_no_clear", {7'd0, clear}, 8'd0);
      chk("rst_count", count, 8'h00);
    end
    rst = 1'b0;
    model_reset();
    repeat (3) step(1'b1);
    press_seen = 0;
    repeat (3) step(1'b0);
    chk("post_rst_pulse", 8'(press_seen), 8'd1);
    chk("post_rst_count", count, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/press_count_display.md
Name: press_count_display

Overview:
- Downstream consumer of the debounced switch level.
- Counts switch releases (falling edges) as a 2-digit BCD value, 00..99 with wrap.
- Long-press clears the count.
- Drives the board's two active-low 7-segment displays, plus status pulses for other logic.

Parameters:
- CLEAR_CYCLES, 50000000, consecutive high cycles of i_Switch that trigger a clear (2 s at 25 MHz). Legal range is >= 2.
- BLANK_LEADING, 1, when 1 the tens display is blanked while the tens digit is 0.

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  reset: asynchronous, active-high
- i_Switch  input  1  debounced switch level, 1 = pressed
- o_Count  output  8  BCD count, [7:4] tens, [3:0] ones
- o_Press_Pulse  output  1  one-cycle pulse on each counted release
- o_Clear_Pulse  output  1  one-cycle pulse when a long-press clear fires
- o_Seg_Tens  output  7  tens display, active-low, bit6 = A ... bit0 = G
- o_Seg_Ones  output  7  ones display, same encoding

Behaviour:
- Reset (async assert, sync release) values:
  - r_Switch = 0, hold counter = 0, suppress flag = 0.
  - o_Count = 8'h00, both pulses = 0, o_Seg_Ones = 7'b0000001.
  - o_Seg_Tens = 7'b1111111 if BLANK_LEADING, else 7'b0000001.
- Edge detect:
  - r_Switch <= i_Switch every cycle.
  - Release = (i_Switch == 0 && r_Switch == 1), evaluated on the same clock edge.
- Hold counter:
  - Cleared to 0 whenever i_Switch == 0.
  - Increments while i_Switch == 1 and saturates at CLEAR_CYCLES.
  - Width = clog2(CLEAR_CYCLES+1).
- Clear event:
  - Fires on the edge where i_Switch == 1 and the hold counter == CLEAR_CYCLES-1, i.e. the CLEAR_CYCLES-th consecutive high sample.
  - Effects: o_Count <= 8'h00, o_Clear_Pulse <= 1 for one cycle, suppress flag <= 1.
  - Fires once per press; saturation prevents a repeat.
- Release event with suppress flag = 1: no increment, no o_Press_Pulse, suppress flag <= 0.
- Release event with suppress flag = 0:
  - o_Count increments in BCD: ones 9 -> 0 with tens +1; 99 -> 00.
  - o_Press_Pulse <= 1 for one cycle.
- Latency:
  - o_Count and the pulses update on the detecting edge.
  - Segment outputs are registered from o_Count, so they lag o_Count by exactly one cycle.
- Simultaneous events:
  - Clear and release cannot coincide, because clear requires i_Switch == 1.
  - Reset dominates everything.
- Reset mid-press:
  - Count goes to 00 immediately; hold counter and suppress flag are cleared.
  - If i_Switch is still high after release of reset, r_Switch follows next cycle and hold counting restarts from 0.
  - The eventual release counts normally, unless a fresh clear fires first.
- No spurious release after reset: r_Switch resets to 0.
- Segment encoding (active-low ABCDEFG):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Digit codes 10..15 cannot occur; the decoder outputs 1111111 (blank) for them.

Decomposition:
- Shared include/package holds:
  - the ten segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the bit-order definition (bit6 = A).
- One natural sub-module: bcd_to_7seg, a combinational 4-bit BCD to 7-bit active-low decoder.
  - Instantiated twice, for tens and ones.
  - Output registering and blanking stay in press_count_display.

Test Plan:
- Bench setup: CLEAR_CYCLES = 8, BLANK_LEADING = 1 unless noted.
- Reset: assert i_Rst with i_Switch = 0.
  - Expect o_Count = 00, both pulses 0, o_Seg_Tens = 1111111, o_Seg_Ones = 0000001.
- Three presses, each high 3 cycles then low 3 cycles.
  - Expect o_Press_Pulse exactly once per release, on the first low sample.
  - Expect o_Count = 8'h03, then o_Seg_Ones = 0000110 one cycle later; tens stays blank.
- 100 short presses.
  - After press 10: expect o_Count = 8'h10 and o_Seg_Tens = 1001111.
  - After press 99: expect 8'h99.
  - After press 100: expect 8'h00, o_Seg_Tens back to 1111111.
- Long press: count 05, hold i_Switch high 12 cycles, then release.
  - Expect o_Clear_Pulse once, on the 8th high cycle, and o_Count = 00.
  - Expect no o_Press_Pulse on release and count stays 00.
  - A following short press gives 01.
- Threshold boundary: press held exactly 7 cycles.
  - Expect no clear; release increments the count by 1.
  - Press held exactly 8 cycles: expect clear and no increment.
- Reset mid-press: count 05, i_Switch high, pulse i_Rst for 2 cycles, keep the switch high 3 more cycles, then release.
  - Expect o_Count = 00 immediately when i_Rst asserts (asynchronous).
  - Expect no pulse during reset.
  - Expect o_Count = 01 with o_Press_Pulse after the release.
